// File: rtl/risc_ctrl_pkg.sv
// Shared types and header-field constants for the risc core program/run controller.
package risc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_ADDR = 2'd1,
        LOAD_DATA = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int          LOAD_BIT             = 7;
    localparam logic [1:0]  OP_RUN               = 2'b01;
    localparam logic [1:0]  OP_HALT              = 2'b00;
    localparam int          BUDGET_FIELD_W       = 6;
    localparam int          DEFAULT_BUDGET_SHIFT = 4;

endpackage

// File: rtl/risc_run_timer.sv
// Loadable run-budget down-counter; expire flags the last cycle of a nonzero budget.
module risc_run_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // A zero count never expires, which is what makes budget 0 unbounded.
    assign expire_o = en_i && !load_i && (count_q == W'(1));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/risc_prog_ctrl.sv
// Host byte-stream sequencer: loads instruction memory, runs the core, captures its result.
module risc_prog_ctrl
    import risc_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 8,
    parameter int BUDGET_SHIFT = DEFAULT_BUDGET_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] inst_address,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_we,
    output logic              cpu_rst_n,
    input  logic [DATA_W-1:0] cpu_mem_out,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              cmd_err
);

    localparam int TW = BUDGET_FIELD_W + BUDGET_SHIFT;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W-1:0]   inst_address_q, inst_address_d;
    logic [DATA_W-1:0]   inst_data_q, inst_data_d;
    logic                inst_we_q, inst_we_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                cmd_err_q, cmd_err_d;
    logic                in_ready_q;

    logic                accept;
    logic                hdr_load, hdr_run, hdr_halt;
    logic                timer_load, timer_expire;
    logic [TW-1:0]       timer_val;

    assign accept    = in_valid && in_ready_q;
    assign hdr_load  = in_data[LOAD_BIT];
    assign hdr_run   = (in_data[7:6] == OP_RUN);
    assign hdr_halt  = (in_data[7:6] == OP_HALT);
    assign timer_val = TW'(in_data[BUDGET_FIELD_W-1:0]) << BUDGET_SHIFT;

    risc_run_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .en_i       (state_q == RUN),
        .expire_o   (timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        remaining_d    = remaining_q;
        inst_address_d = inst_address_q;
        inst_data_d    = inst_data_q;
        inst_we_d      = 1'b0;
        cpu_rst_n_d    = cpu_rst_n_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        cmd_err_d      = cmd_err_q;
        timer_load     = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_rst_n_d = 1'b0;
                if (accept && hdr_load) begin
                    remaining_d = {1'b0, in_data[ADDR_W-1:0]} + 1'b1;
                    state_d     = LOAD_ADDR;
                end else if (accept && hdr_run) begin
                    timer_load     = 1'b1;
                    result_valid_d = 1'b0;
                    cpu_rst_n_d    = 1'b1;
                    state_d        = RUN;
                end
            end
            LOAD_ADDR: begin
                if (accept) begin
                    ptr_d   = in_data[ADDR_W-1:0];
                    state_d = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                if (accept) begin
                    inst_we_d      = 1'b1;
                    inst_address_d = ptr_q;
                    inst_data_d    = in_data;
                    ptr_d          = ptr_q + 1'b1;
                    remaining_d    = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                // Non-HALT headers are rejected but never disturb the run.
                if (accept && !hdr_halt) begin
                    cmd_err_d = 1'b1;
                end
                if ((accept && hdr_halt) || timer_expire) begin
                    result_d       = cpu_mem_out;
                    result_valid_d = 1'b1;
                    cpu_rst_n_d    = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            remaining_q    <= '0;
            inst_address_q <= '0;
            inst_data_q    <= '0;
            inst_we_q      <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            remaining_q    <= remaining_d;
            inst_address_q <= inst_address_d;
            inst_data_q    <= inst_data_d;
            inst_we_q      <= inst_we_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            cmd_err_q      <= cmd_err_d;
            in_ready_q     <= 1'b1;
        end
    end

    assign in_ready     = in_ready_q;
    assign inst_address = inst_address_q;
    assign inst_data    = inst_data_q;
    assign inst_we      = inst_we_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_risc_prog_ctrl.sv
// Directed bench for risc_prog_ctrl: load, wrap, bounded/unbounded runs, errors, mid-load reset.
module tb_risc_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] inst_address;
    logic [7:0] inst_data;
    logic       inst_we;
    logic       cpu_rst_n;
    logic [7:0] cpu_mem_out = 8'h00;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;
    int hi_cnt = 0;
    int we_cnt = 0;
    int we_snap;

    risc_prog_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst_address (inst_address),
        .inst_data    (inst_data),
        .inst_we      (inst_we),
        .cpu_rst_n    (cpu_rst_n),
        .cpu_mem_out  (cpu_mem_out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    // Count core-release cycles and write strobes mid-cycle.
    always @(negedge clk) begin
        if (cpu_rst_n === 1'b1) hi_cnt++;
        if (inst_we === 1'b1) we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        idle_cycles(3);
        check("rst_inst_we", {31'd0, inst_we}, 32'd0);
        check("rst_inst_addr", {25'd0, inst_address}, 32'h0);
        check("rst_inst_data", {24'd0, inst_data}, 32'h0);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        rst = 1'b0;
        idle_cycles(1);

        // Three-byte load at 0x10, streamed back-to-back.
        send(8'h82);
        check("ld_hdr_busy", {31'd0, busy}, 32'd1);
        check("ld_hdr_we", {31'd0, inst_we}, 32'd0);
        send(8'h10);
        send(8'hA1);
        check("ld0_we", {31'd0, inst_we}, 32'd1);
        check("ld0_addr", {25'd0, inst_address}, 32'h10);
        check("ld0_data", {24'd0, inst_data}, 32'hA1);
        send(8'hA2);
        check("ld1_addr", {25'd0, inst_address}, 32'h11);
        check("ld1_data", {24'd0, inst_data}, 32'hA2);
        check("ld1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        send(8'hA3);
        check("ld2_we", {31'd0, inst_we}, 32'd1);
        check("ld2_addr", {25'd0, inst_address}, 32'h12);
        check("ld2_data", {24'd0, inst_data}, 32'hA3);
        check("ld2_busy", {31'd0, busy}, 32'd0);
        idle_cycles(1);
        check("ld_after_we", {31'd0, inst_we}, 32'd0);
        check("ld_hold_addr", {25'd0, inst_address}, 32'h12);
        check("ld_hold_data", {24'd0, inst_data}, 32'hA3);

        // Address pointer wraps from 0x7F to 0x00.
        send(8'h81);
        send(8'h7F);
        send(8'h55);
        check("wrap0_addr", {25'd0, inst_address}, 32'h7F);
        send(8'h66);
        check("wrap1_addr", {25'd0, inst_address}, 32'h00);
        check("wrap1_data", {24'd0, inst_data}, 32'h66);
        check("wrap_busy", {31'd0, busy}, 32'd0);
        idle_cycles(1);

        // Bounded run: budget 2 -> 32 cycles.
        cpu_mem_out = 8'h3C;
        hi_cnt = 0;
        send(8'h42);
        check("run2_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("run2_busy", {31'd0, busy}, 32'd1);
        wait_idle(200);
        check("run2_hi_cycles", hi_cnt, 32'd32);
        check("run2_result", {24'd0, result}, 32'h3C);
        check("run2_result_valid", {31'd0, result_valid}, 32'd1);
        check("run2_cpu_rst_n_off", {31'd0, cpu_rst_n}, 32'd0);
        cpu_mem_out = 8'hFF;
        idle_cycles(5);
        check("run2_result_held", {24'd0, result}, 32'h3C);
        check("run2_valid_held", {31'd0, result_valid}, 32'd1);

        // Unbounded run halted after 100 cycles.
        cpu_mem_out = 8'h5A;
        hi_cnt = 0;
        send(8'h40);
        check("run0_valid_cleared", {31'd0, result_valid}, 32'd0);
        idle_cycles(99);
        check("run0_still_busy", {31'd0, busy}, 32'd1);
        send(8'h00);
        check("run0_hi_cycles", hi_cnt, 32'd100);
        check("run0_result", {24'd0, result}, 32'h5A);
        check("run0_result_valid", {31'd0, result_valid}, 32'd1);
        check("run0_busy", {31'd0, busy}, 32'd0);
        check("run0_cpu_rst_n_off", {31'd0, cpu_rst_n}, 32'd0);

        // HALT lands exactly on the expiry cycle of a 16-cycle run.
        cpu_mem_out = 8'h77;
        hi_cnt = 0;
        send(8'h41);
        idle_cycles(15);
        send(8'h00);
        check("coinc_hi_cycles", hi_cnt, 32'd16);
        check("coinc_result", {24'd0, result}, 32'h77);
        check("coinc_busy", {31'd0, busy}, 32'd0);
        cpu_mem_out = 8'h11;
        idle_cycles(2);
        check("coinc_no_extra", hi_cnt, 32'd16);
        check("coinc_result_kept", {24'd0, result}, 32'h77);

        // HALT in IDLE is a silent no-op.
        send(8'h00);
        check("idle_halt_busy", {31'd0, busy}, 32'd0);
        check("idle_halt_err", {31'd0, cmd_err}, 32'd0);

        // LOAD header during RUN: flagged and discarded.
        cpu_mem_out = 8'h99;
        hi_cnt = 0;
        we_snap = we_cnt;
        send(8'h42);
        idle_cycles(3);
        send(8'h85);
        check("err_flag", {31'd0, cmd_err}, 32'd1);
        check("err_no_we", {31'd0, inst_we}, 32'd0);
        check("err_run_busy", {31'd0, busy}, 32'd1);
        check("err_run_cpu_on", {31'd0, cpu_rst_n}, 32'd1);
        wait_idle(200);
        check("err_hi_cycles", hi_cnt, 32'd32);
        check("err_result", {24'd0, result}, 32'h99);
        check("err_we_count", we_cnt, we_snap);
        check("err_sticky", {31'd0, cmd_err}, 32'd1);

        // Reset in the middle of a four-byte load.
        send(8'h83);
        send(8'h20);
        send(8'h01);
        send(8'h02);
        check("mid_we", {31'd0, inst_we}, 32'd1);
        check("mid_addr", {25'd0, inst_address}, 32'h21);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        we_snap = we_cnt;
        check("mrst_we", {31'd0, inst_we}, 32'd0);
        check("mrst_addr", {25'd0, inst_address}, 32'h0);
        check("mrst_data", {24'd0, inst_data}, 32'h0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("mrst_result", {24'd0, result}, 32'h0);
        check("mrst_result_valid", {31'd0, result_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        send(8'h03);
        idle_cycles(2);
        check("mrst_no_more_we", we_cnt, we_snap);

        // A fresh load works after the reset.
        send(8'h80);
        send(8'h05);
        send(8'hEE);
        check("fresh_we", {31'd0, inst_we}, 32'd1);
        check("fresh_addr", {25'd0, inst_address}, 32'h05);
        check("fresh_data", {24'd0, inst_data}, 32'hEE);
        check("fresh_busy", {31'd0, busy}, 32'd0);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
